// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared constants, state encoding and digit helper for the
//               sequential BCD-to-binary converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR_ADJ    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT   = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] d);
        return (d > BCD_MAX_DIGIT);
    endfunction

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_corr.sv
// ============================================================================
// Module      : bcd_digit_corr
// Description : Combinational reverse double-dabble cell: a digit that reads
//               8 or more after the right shift is reduced by 3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_CORR_THRESH) begin
            o_digit = i_digit - BCD_CORR_ADJ;
        end
    end

endmodule : bcd_digit_corr

`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// Module      : bcd_to_bin_seq
// Description : Bit-serial BCD-to-binary converter with valid/ready on both
//               sides. Optional digit checking enabled by BCD2BIN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter  int DIGITS = 4,
    localparam int OUT_W  = $clog2(10**DIGITS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            out_data,
    output logic                        err,
    output logic                        busy
);

    localparam int BIN_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bcd_q, bcd_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;

    logic [BIN_W-1:0]   w_shift_bcd;
    logic [BIN_W-1:0]   w_shift_bin;
    logic [BIN_W-1:0]   w_corr_bcd;
    logic [OUT_W-1:0]   w_result;

    // Combined {bcd, bin} register shifted right one place per step.
    assign w_shift_bcd = bcd_q >> 1;
    assign w_shift_bin = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_corr u_corr (
            .i_digit (w_shift_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_corr_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // A value below 10**DIGITS never reaches the bits above OUT_W.
    if (OUT_W < BIN_W) begin : g_trunc
        logic [BIN_W-OUT_W-1:0] w_unused_hi;
        assign w_unused_hi = w_shift_bin[BIN_W-1:OUT_W];
        assign w_result    = w_shift_bin[OUT_W-1:0];
    end else begin : g_full
        assign w_result    = w_shift_bin;
    end

`ifdef BCD2BIN_CHECK_EN
    logic bad_q, bad_d;
    logic err_q, err_d;
    logic w_in_bad;

    always_comb begin
        w_in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_in_bad = w_in_bad | bcd_digit_bad(in_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
`ifdef BCD2BIN_CHECK_EN
        bad_d      = bad_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CONV;
                    bcd_d   = in_bcd;
                    bin_d   = '0;
                    cnt_d   = C_CNT_LOAD;
`ifdef BCD2BIN_CHECK_EN
                    bad_d   = w_in_bad;
`endif
                end
            end
            CONV: begin
                bcd_d = w_corr_bcd;
                bin_d = w_shift_bin;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d    = DONE;
`ifdef BCD2BIN_CHECK_EN
                    out_data_d = bad_q ? '0 : w_result;
                    err_d      = bad_q;
`else
                    out_data_d = w_result;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
`ifdef BCD2BIN_CHECK_EN
            bad_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
`ifdef BCD2BIN_CHECK_EN
            bad_q      <= bad_d;
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CONV);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
`ifdef BCD2BIN_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule : bcd_to_bin_seq

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
// Module      : tb_bcd_to_bin_seq
// Description : Self-checking bench for bcd_to_bin_seq (DIGITS=4); honours
//               BCD2BIN_CHECK_EN when deciding the expected err behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic        err;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    bcd_to_bin_seq #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value from the digits, plus a flag for any digit > 9.
    function automatic int ref_val(input logic [15:0] b);
        int v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[i*4 +: 4]);
        return v;
    endfunction

    function automatic bit ref_bad(input logic [15:0] b);
        bit bad = 0;
        for (int i = 0; i < 4; i++) if (b[i*4 +: 4] > 4'd9) bad = 1;
        return bad;
    endfunction

    task automatic accept(input logic [15:0] v);
        for (int k = 0; k < 50 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_bcd   = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("after_accept_busy_ready", {30'd0, busy, in_ready}, 32'd2);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("result_arrives", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic finish_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handshake_valid_ready_busy", {29'd0, out_valid, in_ready, busy}, 32'd2);
    endtask

    task automatic check_result(input logic [15:0] v);
        bit bad = ref_bad(v);
        chk("done_in_ready_low", {31'd0, in_ready}, 32'd0);
`ifdef BCD2BIN_CHECK_EN
        chk("out_data", {18'd0, out_data}, bad ? 32'd0 : 32'(ref_val(v)));
        chk("err", {31'd0, err}, {31'd0, bad});
`else
        if (!bad) chk("out_data", {18'd0, out_data}, 32'(ref_val(v)));
        chk("err", {31'd0, err}, 32'd0);
`endif
    endtask

    task automatic convert(input logic [15:0] v);
        int lat;
        accept(v);
        wait_result(lat);
        // lat counts edges after the accept edge
        chk("latency", 32'(lat), 32'd16);
        check_result(v);
        finish_result();
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            seen = seen | out_valid | busy;
        end
        chk(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [15:0] v;
        int          lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;
        #12;
        chk("reset_state", {14'd0, in_ready, out_valid, busy, err, out_data}, 32'h20000);
        rst = 1'b0;
        @(posedge clk); #1;

        convert(16'h9999);
        convert(16'h0000);
        convert(16'h1234);
        convert(16'h0007);

        // Asynchronous reset while idle must clear the retained result.
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("idle_reset_state", {14'd0, in_ready, out_valid, busy, err, out_data}, 32'h20000);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;

        // Backpressure: result holds, a new request is ignored.
        v = 16'h0321;
        accept(v);
        wait_result(lat);
        check_result(v);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_bcd   = 16'h5555;
            @(posedge clk); #1;
            chk("bp_hold", {16'd0, out_valid, in_ready, out_data}, {16'd0, 2'b10, 14'(ref_val(v))});
        end
        in_valid = 1'b0;
        finish_result();
        expect_silence("bp_no_accept", 4);

        convert(16'h12A4);

        // Abort a conversion in its 7th step, then confirm a clean restart.
        accept(16'h9999);
        repeat (7) begin
            @(posedge clk);
        end
        #3;
        rst = 1'b1;
        #1;
        chk("abort_reset_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
        #2;
        rst = 1'b0;
        expect_silence("abort_no_output", 20);
        convert(16'h0042);
        expect_silence("single_result", 20);

        for (int n = 0; n < 20; n++) begin
            v = '0;
            for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
            convert(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_bcd_to_bin_seq

`default_nettype wire
